md_scheduler: RTL and testbench

Multiply/divide sequencer for the five-stage pipeline. It accepts a multiply, divide, or HI/LO-move operation from the E stage and holds the result in pending registers. It commits HI/LO after a fixed per-operation latency and tells the hazard logic to stall a D-stage multiply/divide instruction while the unit is occupied. MFHI/MFLO read `hi`/`lo` directly; forwarding for them is not this block's concern.

---
 rtl/md_scheduler.sv | 139 +++++++++++++
 tb/tb_md_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// rtl/md_scheduler.sv - multiply/divide sequencer holding HI/LO with fixed per-op latency
// Optional divider enabled by defining MD_DIV_EN; without it DIV/DIVU behave as NONE.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [63:0] prod_s, prod_u;

    assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u = {32'b0, rs_data} * {32'b0, rt_data};

`ifdef MD_DIV_EN
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_DIVU = 3'd4;

    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    // Divide-by-zero and the single signed overflow case are resolved explicitly
    always_comb begin
        quot_u = 32'hFFFF_FFFF;
        rem_u  = rs_data;
        quot_s = 32'hFFFF_FFFF;
        rem_s  = rs_data;
        if (rt_data != 32'd0) begin
            quot_u = rs_data / rt_data;
            rem_u  = rs_data % rt_data;
            if (rs_data == 32'h8000_0000 && rt_data == 32'hFFFF_FFFF) begin
                quot_s = 32'h8000_0000;
                rem_s  = 32'd0;
            end else begin
                quot_s = $signed(rs_data) / $signed(rt_data);
                rem_s  = $signed(rs_data) % $signed(rt_data);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d   = 32'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d   = 32'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
`ifdef MD_DIV_EN
                        OP_DIV: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quot_s;
                            cnt_d     = 32'(DIV_CYCLES);
                            state_d   = S_BUSY;
                        end
                        OP_DIVU: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quot_u;
                            cnt_d     = 32'(DIV_CYCLES);
                            state_d   = S_BUSY;
                        end
`endif
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // Any start seen here is dropped; hazard logic should have stalled it
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = (state_q == S_BUSY);
    assign stall_req = md_use_d & (start | busy);

endmodule

// File: tb/tb_md_scheduler.sv
// tb/tb_md_scheduler.sv - self-checking bench for md_scheduler (honours MD_DIV_EN)
module tb_md_scheduler;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MD_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data, rt_data;
    logic        md_use_d;
    logic [31:0] hi, lo;
    logic        busy, stall_req;

    int vectors = 0;
    int miscompares = 0;

    md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_data(rs_data), .rt_data(rt_data), .md_use_d(md_use_d),
        .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted op schedules its result for a known cycle
    int          cyc;
    bit          m_pend;
    int          m_end;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; cyc = 0; m_end = 0;
        end else begin
            if (m_pend) begin
                if (cyc == m_end) begin
                    m_hi = m_phi; m_lo = m_plo; m_pend = 0;
                end
            end else if (start) begin
                case (md_op)
                    3'd1: begin
                        longint p;
                        p = longint'($signed(rs_data)) * longint'($signed(rt_data));
                        {m_phi, m_plo} = p; m_pend = 1; m_end = cyc + MC;
                    end
                    3'd2: begin
                        logic [63:0] p;
                        p = {32'b0, rs_data} * {32'b0, rt_data};
                        {m_phi, m_plo} = p; m_pend = 1; m_end = cyc + MC;
                    end
                    3'd3, 3'd4: if (DIV_ON) begin
                        if (rt_data == 0) begin
                            m_plo = 32'hFFFF_FFFF; m_phi = rs_data;
                        end else if (md_op == 3'd4) begin
                            m_plo = rs_data / rt_data; m_phi = rs_data % rt_data;
                        end else begin
                            int a, b;
                            a = rs_data; b = rt_data;
                            if (a == 32'h8000_0000 && b == -1) begin
                                m_plo = 32'h8000_0000; m_phi = 0;
                            end else begin
                                m_plo = a / b; m_phi = a % b;
                            end
                        end
                        m_pend = 1; m_end = cyc + DC;
                    end
                    3'd5: m_hi = rs_data;
                    3'd6: m_lo = rs_data;
                    default: ;
                endcase
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("model_busy", {31'b0, busy}, {31'b0, m_pend});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
            chk("model_stall", {31'b0, stall_req}, {31'b0, md_use_d & (start | m_pend)});
        end
    end

    task automatic apply(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ud);
        @(posedge clk); #1;
        start = st; md_op = op; rs_data = a; rt_data = b; md_use_d = ud;
    endtask

    // Issue one op, scramble operands afterwards, count busy and stall cycles
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ud, input int inj, output int nbusy, output int nstall);
        int k;
        apply(1'b1, op, a, b, ud);
        @(negedge clk);
        nstall = int'(stall_req);
        nbusy  = 0;
        for (k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == inj) begin
                start = 1'b1; md_op = 3'd5; rs_data = 32'h1234;
            end else begin
                start = 1'b0; md_op = 3'd0; rs_data = ~a; rt_data = ~b;
            end
            @(negedge clk);
            if (!busy) break;
            nbusy++;
            nstall += int'(stall_req);
        end
        if (k == 40) chk("busy_bound", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int nb, ns;
        logic [31:0] eh, el;
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, ns;
        logic [31:0] eh, el;
        reset = 1'b0; start = 1'b0; md_op = 3'd0; rs_data = 0; rt_data = 0; md_use_d = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        do_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, -1, nb, ns);
        chk("mult_busy_cycles", nb, MC);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        do_op(3'd4, 32'd7, 32'd2, 1'b0, -1, nb, ns);
        eh = DIV_ON ? 32'd1 : 32'hFFFF_FFFF;
        el = DIV_ON ? 32'd3 : 32'hFFFF_FFF1;
        chk("divu_busy_cycles", nb, DIV_ON ? DC : 0);
        chk("divu_hi", hi, eh);
        chk("divu_lo", lo, el);

        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, nb, ns);
        if (DIV_ON) begin eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFD; end
        chk("div_neg_hi", hi, eh);
        chk("div_neg_lo", lo, el);

        do_op(3'd4, 32'd9, 32'd0, 1'b0, -1, nb, ns);
        if (DIV_ON) begin eh = 32'd9; el = 32'hFFFF_FFFF; end
        chk("divu_zero_busy", nb, DIV_ON ? DC : 0);
        chk("divu_zero_hi", hi, eh);
        chk("divu_zero_lo", lo, el);

        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, nb, ns);
        if (DIV_ON) begin eh = 32'd0; el = 32'h8000_0000; end
        chk("div_ovf_hi", hi, eh);
        chk("div_ovf_lo", lo, el);

        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 2, nb, ns);
        chk("multu_stall_cycles", ns, MC + 1);
        chk("multu_busy_cycles", nb, MC);
        chk("multu_hi", hi, 32'd1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        do_op(3'd6, 32'hCAFE_0000, 32'd0, 1'b1, -1, nb, ns);
        chk("mtlo_busy_cycles", nb, 0);
        chk("mtlo_stall_cycles", ns, 1);
        chk("mtlo_lo", lo, 32'hCAFE_0000);
        chk("mtlo_hi", hi, 32'd1);

        do_op(3'd7, 32'hDEAD_BEEF, 32'd3, 1'b0, -1, nb, ns);
        chk("reserved_busy", nb, 0);
        chk("reserved_lo", lo, 32'hCAFE_0000);

        do_op(3'd5, 32'h55, 32'd0, 1'b0, -1, nb, ns);
        chk("mthi_hi", hi, 32'h55);

        apply(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        apply(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        @(posedge clk); #3;
        chk("busy_before_reset", {31'b0, busy}, {31'b0, DIV_ON});
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        do_op(3'd1, 32'd3, 32'd4, 1'b0, -1, nb, ns);
        chk("post_reset_lo", lo, 32'd12);
        chk("post_reset_hi", hi, 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
